// File: rtl/vector_sequencer.sv
//------------------------------------------------------------------------------
// vector_sequencer
//
// Stimulus/check engine for a small combinational DUT. A packed vector memory
// holds {inputs, expected} words. On start the engine walks vectors
// 0..num_vec-1. For each vector it drives the inputs onto dut_in_o, holds
// them for SETTLE cycles, then spends one cycle comparing dut_out_i against
// the stored expected value. Pass/fail status is accumulated as it goes.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset. Assertion takes effect
//                   immediately; release is synchronised internally.
//   wr_en_i         vector memory write strobe (honoured only in IDLE/DONE)
//   wr_addr_i       write address. Addresses >= DEPTH are dropped.
//   wr_data_i       packed vector {inputs, expected}; inputs in the MSBs
//   num_vec_i       number of vectors to run, latched on start and clamped
//                   to DEPTH
//   stop_on_fail_i  halt at the first mismatch; latched on start
//   start_i         single-cycle run request (ignored while busy)
//   dut_in_o        registered stimulus to the DUT
//   dut_out_i       DUT response
//   busy_o          high while a run is in progress (APPLY/CHECK)
//   done_o          run finished; held until the next start
//   pass_o          run finished with no mismatches
//   err_count_o     saturating mismatch count
//   vec_idx_o       index of the vector being applied/checked
//   fail_idx_o      index of the first mismatch; valid when err_count_o != 0
//
// Timing: the start edge itself loads vector 0 onto dut_in_o. Each vector
// then occupies SETTLE APPLY cycles plus one CHECK cycle. A run of N vectors
// therefore raises done_o N*(SETTLE+1) cycles after the start edge. A run
// with num_vec == 0 raises done_o on the start edge.
//------------------------------------------------------------------------------
module vector_sequencer #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [IN_W+OUT_W-1:0]   wr_data_i,
    input  logic [ADDR_W:0]         num_vec_i,
    input  logic                    stop_on_fail_i,
    input  logic                    start_i,
    output logic [IN_W-1:0]         dut_in_o,
    input  logic [OUT_W-1:0]        dut_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [ADDR_W:0]         err_count_o,
    output logic [ADDR_W-1:0]       vec_idx_o,
    output logic [ADDR_W-1:0]       fail_idx_o
);

    localparam int               VEC_W       = IN_W + OUT_W;
    localparam logic [ADDR_W:0]  DEPTH_W     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  ERR_MAX     = '1;
    localparam logic [ADDR_W:0]  ONE_W       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    // The settle counter runs 0..SETTLE-1 while in APPLY.
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;

    // Internal reset: asserts with rst_ni, releases two clocks later.
    logic                rst_meta_q;
    logic                rst_sync_q;

    // Run configuration latched at start.
    logic [ADDR_W:0]     num_vec_q, num_vec_d;
    logic                stop_q, stop_d;

    // Per-vector state.
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   vec_idx_q, vec_idx_d;
    logic [IN_W-1:0]     dut_in_q;
    logic [OUT_W-1:0]    exp_q;

    // Status.
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   fail_idx_q, fail_idx_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    // Vector memory (contents deliberately not reset).
    logic [VEC_W-1:0]    mem [DEPTH];

    // Control decoded from the state.
    logic                idle_like;
    logic                start_ok;
    logic                wr_ok;
    logic [ADDR_W:0]     num_clamped;
    logic                run_empty;
    logic                settle_end;
    logic                mismatch;
    logic                last_vec;
    logic                halt;
    logic                busy;
    logic                load_first;
    logic                load_next;
    logic                check_en;
    logic                finish;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;

    //--------------------------------------------------------------------------
    // Reset synchroniser
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    //--------------------------------------------------------------------------
    // Shared decode
    //--------------------------------------------------------------------------
    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok    = idle_like && start_i;
    assign wr_ok       = idle_like && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_W);
    assign num_clamped = (num_vec_i > DEPTH_W) ? DEPTH_W : num_vec_i;
    assign run_empty   = (num_clamped == '0);
    assign settle_end  = (cnt_q == SETTLE_LAST);
    // Case inequality so that an undriven or X response counts as a failure
    // in simulation. Synthesis treats it as an ordinary inequality.
    assign mismatch    = (dut_out_i !== exp_q);
    assign last_vec    = ({1'b0, vec_idx_q} == (num_vec_q - ONE_W));
    assign halt        = (mismatch && stop_q) || last_vec;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = run_empty ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                if (settle_end) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = halt ? S_DONE : S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    //--------------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        check_en   = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                load_first = start_i && !run_empty;
                finish     = start_i && run_empty;
            end
            S_APPLY: begin
                busy = 1'b1;
            end
            S_CHECK: begin
                busy      = 1'b1;
                check_en  = 1'b1;
                load_next = !halt;
                finish    = halt;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // The vector is fetched on the edge that enters APPLY, so dut_in changes
    // on that same edge and the settle count starts there.
    assign rd_en   = load_first || load_next;
    assign rd_addr = load_first ? '0 : (vec_idx_q + ONE_A);

    //--------------------------------------------------------------------------
    // Datapath next-state
    //--------------------------------------------------------------------------
    always_comb begin
        num_vec_d  = num_vec_q;
        stop_d     = stop_q;
        cnt_d      = cnt_q;
        vec_idx_d  = vec_idx_q;
        err_d      = err_q;
        fail_idx_d = fail_idx_q;
        done_d     = done_q;
        pass_d     = pass_q;

        if (start_ok) begin
            num_vec_d  = num_clamped;
            stop_d     = stop_on_fail_i;
            vec_idx_d  = '0;
            err_d      = '0;
            fail_idx_d = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end

        if (state_q == S_APPLY) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (rd_en) begin
            cnt_d = '0;
        end

        if (check_en && mismatch) begin
            if (err_q == '0) begin
                fail_idx_d = vec_idx_q;
            end
            if (err_q != ERR_MAX) begin
                err_d = err_q + ONE_W;
            end
        end

        if (load_next) begin
            vec_idx_d = vec_idx_q + ONE_A;
        end

        // pass must reflect the final compare, so it uses err_d.
        if (finish) begin
            done_d = 1'b1;
            pass_d = (err_d == '0);
        end
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            num_vec_q  <= '0;
            stop_q     <= 1'b0;
            cnt_q      <= '0;
            vec_idx_q  <= '0;
            err_q      <= '0;
            fail_idx_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            num_vec_q  <= num_vec_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_d;
            vec_idx_q  <= vec_idx_d;
            err_q      <= err_d;
            fail_idx_q <= fail_idx_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    //--------------------------------------------------------------------------
    // Vector memory: write port plus registered read into dut_in/expected.
    // A write and a read of the same address on one edge return the old word.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            dut_in_q <= '0;
            exp_q    <= '0;
        end else if (rd_en) begin
            dut_in_q <= mem[rd_addr][VEC_W-1:OUT_W];
            exp_q    <= mem[rd_addr][OUT_W-1:0];
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign dut_in_o    = dut_in_q;
    assign busy_o      = busy;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign vec_idx_o   = vec_idx_q;
    assign fail_idx_o  = fail_idx_q;

endmodule

// File: tb/tb_vector_sequencer.sv
`timescale 1ns/1ps
module tb_vector_sequencer;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 1;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int VEC_W  = IN_W + OUT_W;
    localparam int OBS_N  = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en1 = 1'b0, wr_en3 = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [VEC_W-1:0]  wr_data = '0;
    logic [ADDR_W:0]   num_vec = '0;
    logic stop_on_fail = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;

    logic [IN_W-1:0]   dut_in1, dut_in3;
    logic [OUT_W-1:0]  dut_out1, dut_out3;
    logic busy1, done1, pass1, busy3, done3, pass3;
    logic [ADDR_W:0]   err1, err3;
    logic [ADDR_W-1:0] idx1, idx3, fidx1, fidx3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational device being exercised: y = ~b&~c | a&~b, dut_in = {a,b,c}.
    function automatic logic sf(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign dut_out1 = sf(dut_in1);
    assign dut_out3 = sf(dut_in3);

    vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en1), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .num_vec_i(num_vec), .stop_on_fail_i(stop_on_fail), .start_i(start1),
        .dut_in_o(dut_in1), .dut_out_i(dut_out1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .vec_idx_o(idx1), .fail_idx_o(fidx1));

    vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en3), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .num_vec_i(num_vec), .stop_on_fail_i(stop_on_fail), .start_i(start3),
        .dut_in_o(dut_in3), .dut_out_i(dut_out3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .err_count_o(err3), .vec_idx_o(idx3), .fail_idx_o(fidx3));

    // Truth table of sf as {a,b,c,y}.
    logic [VEC_W-1:0] tt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                                 4'b1001, 4'b1011, 4'b1100, 4'b1110};

    // Reference model state.
    logic [VEC_W-1:0] m_mem [DEPTH];
    int m_err, m_fail, m_last, m_nexec;
    bit m_pass;

    // Observations from the latest run.
    int obs_elapsed;
    bit obs_timeout;
    logic [IN_W-1:0]   obs_in  [OBS_N];
    logic              obs_busy[OBS_N];
    logic [ADDR_W:0]   obs_err [OBS_N];
    logic [ADDR_W-1:0] obs_idx [OBS_N];
    logic [IN_W-1:0]   pre_in;
    logic r_done, r_busy, r_pass;
    logic [IN_W-1:0]   r_in;
    logic [ADDR_W:0]   r_err;
    logic [ADDR_W-1:0] r_idx, r_fidx;

    // Optional mid-run start+write pulse.
    int pulse_at = -1;
    logic [ADDR_W-1:0] pulse_addr = '0;
    logic [VEC_W-1:0]  pulse_data = '0;

    // Walk the vectors in order, the way the engine is meant to behave.
    task automatic model_run(input int num, input bit stop);
        int n;
        bit mis;
        n = (num > DEPTH) ? DEPTH : num;
        m_err = 0; m_fail = 0; m_last = 0; m_nexec = 0;
        for (int i = 0; i < n; i++) begin
            mis = (sf(m_mem[i][VEC_W-1:OUT_W]) != m_mem[i][0]);
            m_nexec++;
            m_last = i;
            if (mis) begin
                if (m_err == 0) m_fail = i;
                if (m_err < 31) m_err++;
            end
            if (mis && stop) break;
        end
        m_pass = (m_err == 0);
    endtask

    task automatic write_vec(input int addr, input logic [VEC_W-1:0] data);
        @(negedge clk);
        wr_en1 = 1'b1; wr_en3 = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en1 = 1'b0; wr_en3 = 1'b0;
        m_mem[addr] = data;
    endtask

    // Entries 0..7: truth table (optionally one expected bit flipped);
    // entries 8..15: further correct vectors.
    task automatic load_table(input int flip);
        logic [2:0] v;
        for (int i = 0; i < 8; i++)
            write_vec(i, tt[i] ^ {3'b000, (i == flip)});
        for (int i = 8; i < DEPTH; i++) begin
            v = 3'(i * 5 + 3);
            write_vec(i, {v, sf(v)});
        end
    endtask

    task automatic sample_outputs(input int sel);
        if (sel == 3) begin
            r_done = done3; r_busy = busy3; r_pass = pass3; r_in = dut_in3;
            r_err = err3; r_idx = idx3; r_fidx = fidx3;
        end else begin
            r_done = done1; r_busy = busy1; r_pass = pass1; r_in = dut_in1;
            r_err = err1; r_idx = idx1; r_fidx = fidx1;
        end
    endtask

    // Start a run and record outputs at each negedge; obs_elapsed counts
    // clock edges after the start edge.
    task automatic run_dut(input int sel, input int num, input bit stop);
        @(negedge clk);
        num_vec = (ADDR_W+1)'(num);
        stop_on_fail = stop;
        pre_in = (sel == 3) ? dut_in3 : dut_in1;
        if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        obs_elapsed = 0;
        obs_timeout = 1'b0;
        forever begin
            sample_outputs(sel);
            if (obs_elapsed < OBS_N) begin
                obs_in[obs_elapsed]   = r_in;
                obs_busy[obs_elapsed] = r_busy;
                obs_err[obs_elapsed]  = r_err;
                obs_idx[obs_elapsed]  = r_idx;
            end
            if (r_done) break;
            if (obs_elapsed >= 300) begin obs_timeout = 1'b1; break; end
            if (obs_elapsed == pulse_at) begin
                if (sel == 3) begin start3 = 1'b1; wr_en3 = 1'b1; end
                else          begin start1 = 1'b1; wr_en1 = 1'b1; end
                wr_addr = pulse_addr;
                wr_data = pulse_data;
            end
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0; wr_en1 = 1'b0; wr_en3 = 1'b0;
            obs_elapsed++;
        end
        $display("run sel=%0d num=%0d stop=%0d elapsed=%0d done=%0d pass=%0d err=%0d idx=%0d fidx=%0d dut_in=%0d",
                 sel, num, stop, obs_elapsed, r_done, r_pass, r_err, r_idx, r_fidx, r_in);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dut_in1 !== 3'd0) begin errors++; $display("FAIL reset_dut_in: got %0d expected 0", dut_in1); end
        checks++; if ({busy1, done1, pass1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy1, done1, pass1}); end
        checks++; if ({err1, idx1, fidx1} !== '0) begin errors++; $display("FAIL reset_counts: got err=%0d idx=%0d fidx=%0d expected 0", err1, idx1, fidx1); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_truth_table();
        load_table(-1);
        model_run(8, 1'b0);
        run_dut(1, 8, 1'b0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL tt_timeout: got no done expected done"); end
        checks++; if (obs_elapsed != 16) begin errors++; $display("FAIL tt_latency: got %0d expected 16", obs_elapsed); end
        checks++; if (r_pass !== 1'b1 || r_err !== '0) begin errors++; $display("FAIL tt_pass: got pass=%0d err=%0d expected pass=1 err=0", r_pass, r_err); end
        checks++; if (r_idx !== 4'd7) begin errors++; $display("FAIL tt_idx: got %0d expected 7", r_idx); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_in[2*k] !== 3'(k) || obs_busy[2*k] !== 1'b1 || obs_idx[2*k] !== 4'(k)) begin
                errors++;
                $display("FAIL tt_step%0d: got dut_in=%0d busy=%0d idx=%0d expected dut_in=%0d busy=1 idx=%0d",
                         k, obs_in[2*k], obs_busy[2*k], obs_idx[2*k], k, k);
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL tt_done_hold: got done=%0d busy=%0d expected done=1 busy=0", done1, busy1); end
    endtask

    task automatic test_fail_continue();
        load_table(5);
        run_dut(1, 8, 1'b0);
        checks++; if (obs_elapsed != 16 || obs_timeout) begin errors++; $display("FAIL fc_latency: got %0d expected 16", obs_elapsed); end
        checks++; if (r_pass !== 1'b0 || r_err !== 5'd1) begin errors++; $display("FAIL fc_status: got pass=%0d err=%0d expected pass=0 err=1", r_pass, r_err); end
        checks++; if (r_fidx !== 4'd5) begin errors++; $display("FAIL fc_fail_idx: got %0d expected 5", r_fidx); end
        checks++; if (obs_err[11] !== 5'd0 || obs_err[12] !== 5'd1) begin errors++; $display("FAIL fc_err_timing: got %0d,%0d expected 0,1", obs_err[11], obs_err[12]); end
    endtask

    task automatic test_stop_on_fail();
        run_dut(1, 8, 1'b1);
        checks++; if (obs_elapsed != 12 || obs_timeout) begin errors++; $display("FAIL sf_latency: got %0d expected 12", obs_elapsed); end
        checks++; if (r_idx !== 4'd5 || r_err !== 5'd1 || r_fidx !== 4'd5) begin errors++; $display("FAIL sf_status: got idx=%0d err=%0d fidx=%0d expected 5,1,5", r_idx, r_err, r_fidx); end
        repeat (3) @(negedge clk);
        checks++; if (dut_in1 !== 3'b101 || pass1 !== 1'b0) begin errors++; $display("FAIL sf_hold: got dut_in=%0d pass=%0d expected 5,0", dut_in1, pass1); end
    endtask

    task automatic test_zero_and_clamp();
        run_dut(1, 0, 1'b0);
        checks++; if (obs_elapsed != 0 || r_pass !== 1'b1 || r_err !== '0) begin errors++; $display("FAIL zero_run: got elapsed=%0d pass=%0d err=%0d expected 0,1,0", obs_elapsed, r_pass, r_err); end
        checks++; if (r_in !== pre_in) begin errors++; $display("FAIL zero_dut_in: got %0d expected %0d", r_in, pre_in); end
        load_table(-1);
        run_dut(1, 20, 1'b0);
        checks++; if (obs_elapsed != 32 || obs_timeout) begin errors++; $display("FAIL clamp_latency: got %0d expected 32", obs_elapsed); end
        checks++; if (r_idx !== 4'd15 || r_pass !== 1'b1) begin errors++; $display("FAIL clamp_status: got idx=%0d pass=%0d expected 15,1", r_idx, r_pass); end
    endtask

    task automatic test_reset_midrun();
        load_table(1);
        @(negedge clk);
        num_vec = 5'd8; stop_on_fail = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (err1 !== 5'd1 || busy1 !== 1'b1) begin errors++; $display("FAIL rm_precond: got err=%0d busy=%0d expected 1,1", err1, busy1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({dut_in1, idx1, fidx1, err1} !== '0 || {busy1, done1, pass1} !== 3'b000) begin
            errors++;
            $display("FAIL rm_async: got dut_in=%0d idx=%0d fidx=%0d err=%0d busy=%0d done=%0d pass=%0d expected all 0",
                     dut_in1, idx1, fidx1, err1, busy1, done1, pass1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        write_vec(1, tt[1]);
        model_run(8, 1'b0);
        run_dut(1, 8, 1'b0);
        checks++; if (obs_elapsed != 16 || r_pass !== 1'b1 || obs_in[0] !== 3'd0) begin errors++; $display("FAIL rm_rerun: got elapsed=%0d pass=%0d first=%0d expected 16,1,0", obs_elapsed, r_pass, obs_in[0]); end
    endtask

    task automatic test_busy_ignored();
        load_table(3);
        model_run(8, 1'b0);
        for (int r = 0; r < 2; r++) begin
            pulse_at = 2; pulse_addr = 4'd3; pulse_data = 4'b0110;
            run_dut(1, 8, 1'b0);
            pulse_at = -1;
            checks++; if (obs_elapsed != m_nexec * 2 || obs_timeout) begin errors++; $display("FAIL busy_latency%0d: got %0d expected %0d", r, obs_elapsed, m_nexec * 2); end
            checks++; if (r_err !== 5'(m_err) || r_fidx !== 4'(m_fail) || r_pass !== m_pass) begin
                errors++;
                $display("FAIL busy_result%0d: got err=%0d fidx=%0d pass=%0d expected %0d,%0d,%0d", r, r_err, r_fidx, r_pass, m_err, m_fail, m_pass);
            end
        end
    endtask

    task automatic test_settle3();
        load_table(2);
        run_dut(3, 8, 1'b0);
        checks++; if (obs_elapsed != 32 || obs_timeout) begin errors++; $display("FAIL s3_latency: got %0d expected 32", obs_elapsed); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_in[4*k] !== 3'(k) || obs_in[4*k+3] !== 3'(k)) begin
                errors++;
                $display("FAIL s3_step%0d: got %0d,%0d expected %0d", k, obs_in[4*k], obs_in[4*k+3], k);
            end
        end
        checks++; if (obs_err[11] !== 5'd0 || obs_err[12] !== 5'd1) begin errors++; $display("FAIL s3_err_timing: got %0d,%0d expected 0,1", obs_err[11], obs_err[12]); end
        checks++; if (r_fidx !== 4'd2 || r_err !== 5'd1) begin errors++; $display("FAIL s3_status: got fidx=%0d err=%0d expected 2,1", r_fidx, r_err); end
    endtask

    task automatic test_random();
        int sel, num, s;
        bit stop;
        logic [2:0] v;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 3'($urandom_range(0, 7));
                write_vec(i, {v, sf(v) ^ ($urandom_range(0, 4) == 0)});
            end
            sel  = ($urandom_range(0, 1) == 1) ? 3 : 1;
            s    = sel;
            num  = $urandom_range(0, 20);
            stop = 1'($urandom_range(0, 1));
            model_run(num, stop);
            run_dut(sel, num, stop);
            checks++; if (obs_elapsed != m_nexec * (s + 1) || obs_timeout) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, obs_elapsed, m_nexec * (s + 1)); end
            checks++; if (r_err !== 5'(m_err) || r_pass !== m_pass) begin errors++; $display("FAIL rnd%0d_status: got err=%0d pass=%0d expected %0d,%0d", it, r_err, r_pass, m_err, m_pass); end
            if (m_err != 0) begin
                checks++; if (r_fidx !== 4'(m_fail)) begin errors++; $display("FAIL rnd%0d_fidx: got %0d expected %0d", it, r_fidx, m_fail); end
            end
            if (m_nexec != 0) begin
                checks++; if (r_idx !== 4'(m_last)) begin errors++; $display("FAIL rnd%0d_idx: got %0d expected %0d", it, r_idx, m_last); end
            end
            for (int k = 0; k < m_nexec; k++) begin
                checks++;
                if (obs_in[k * (s + 1)] !== m_mem[k][VEC_W-1:OUT_W]) begin
                    errors++;
                    $display("FAIL rnd%0d_vec%0d: got %0d expected %0d", it, k, obs_in[k * (s + 1)], m_mem[k][VEC_W-1:OUT_W]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_fail_continue();
        test_stop_on_fail();
        test_zero_and_clamp();
        test_reset_midrun();
        test_busy_ignored();
        test_settle3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
